uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/parity_calc.sv | 12 +
 rtl/uart_tx_ctrl.sv | 90 +++++++++
 tb/tb_uart_tx_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: FSM state encoding and the output-mux select codes.
// The same select constants are used by the downstream line mux.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] START_SEL = 2'b00;
  localparam logic [1:0] DATA_SEL  = 2'b01;
  localparam logic [1:0] PAR_SEL   = 2'b10;
  localparam logic [1:0] STOP_SEL  = 2'b11;

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      START:   sel_of = START_SEL;
      DATA:    sel_of = DATA_SEL;
      PARITY:  sel_of = PAR_SEL;
      default: sel_of = STOP_SEL;
    endcase
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Parity of a payload word: even parity (par_type=0) or odd parity (par_type=1).
module parity_calc #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_type,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ par_type;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: Moore FSM sequencing start, data, optional parity and stop bits.
// Optional parity support is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;

`ifdef UART_TX_PARITY_EN
  logic par_typ_q;
  logic par_calc;

  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data     (data_q),
    .par_type (par_typ_q),
    .par_bit  (par_calc)
  );

  assign par_bit = par_calc;
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
  assign par_bit    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_typ_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (DATA_VALID) begin
            data_q <= P_DATA;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
`else
            par_en_q  <= 1'b0;
`endif
            state <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= DATA;
        end
        DATA: begin
          if (cnt == LAST) begin
            state <= par_en_q ? PARITY : STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY:  state <= STOP;
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mux_sel  = sel_of(state);
  assign busy     = (state != IDLE);
  assign ser_data = (state == DATA) ? data_q[cnt] : 1'b0;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: per-cycle expected line behaviour is queued at request
// time and popped while the frame runs. Parity expectations follow `UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [1:0]    mux_sel;
  logic          ser_data;
  logic          par_bit;
  logic          busy;

  typedef struct {
    logic [1:0] sel;
    logic       ser;
    logic       par;
    logic       bsy;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Queue the per-cycle expectation of one whole frame, START through STOP.
  task automatic push_frame(input logic [DW-1:0] d, input logic en, input logic typ);
    exp_t e;
    logic p;
    p = PAR_BUILD ? ((^d) ^ typ) : 1'b0;
    e = '{sel: 2'b00, ser: 1'b0, par: p, bsy: 1'b1};
    exp_q.push_back(e);
    for (int i = 0; i < DW; i++) begin
      e = '{sel: 2'b01, ser: d[i], par: p, bsy: 1'b1};
      exp_q.push_back(e);
    end
    if (PAR_BUILD && en) begin
      e = '{sel: 2'b10, ser: 1'b0, par: p, bsy: 1'b1};
      exp_q.push_back(e);
    end
    e = '{sel: 2'b11, ser: 1'b0, par: p, bsy: 1'b1};
    exp_q.push_back(e);
  endtask

  // Consume the queue one cycle per entry; optionally pulse a new request in DATA.
  task automatic run_queue(input string name, input bit disturb);
    exp_t e;
    int   idx;
    int   busy_cnt;
    int   exp_len;
    idx = 0;
    busy_cnt = 0;
    exp_len = exp_q.size();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (mux_sel !== e.sel || ser_data !== e.ser || par_bit !== e.par || busy !== e.bsy)
        $display("FAIL %s cyc%0d: got sel=%b ser=%b par=%b busy=%b, want sel=%b ser=%b par=%b busy=%b",
                 name, idx, mux_sel, ser_data, par_bit, busy, e.sel, e.ser, e.par, e.bsy);
      else passed++;
      if (busy === 1'b1) busy_cnt++;
      if (disturb && idx == 3) begin
        DATA_VALID = 1'b1;
        P_DATA     = 8'h3C;
        PAR_EN     = ~PAR_EN;
        PAR_TYP    = ~PAR_TYP;
      end else if (disturb && idx == 4) begin
        DATA_VALID = 1'b0;
      end
      idx++;
      @(posedge CLK); #1;
    end
    total++;
    if (busy_cnt !== exp_len) $display("FAIL %s busy_len: got %0d want %0d", name, busy_cnt, exp_len);
    else passed++;
  endtask

  task automatic check_idle(input string name);
    total++;
    if (mux_sel !== 2'b11 || ser_data !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s idle: got sel=%b ser=%b busy=%b, want sel=11 ser=0 busy=0",
               name, mux_sel, ser_data, busy);
    else passed++;
  endtask

  task automatic send(input string name, input logic [DW-1:0] d, input logic en,
                      input logic typ, input bit disturb);
    @(negedge CLK);
    P_DATA = d; PAR_EN = en; PAR_TYP = typ; DATA_VALID = 1'b1;
    push_frame(d, en, typ);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    run_queue(name, disturb);
    check_idle(name);
  endtask

  task automatic test_reset();
    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (mux_sel !== 2'b11 || ser_data !== 1'b0 || par_bit !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset: got sel=%b ser=%b par=%b busy=%b, want 11 0 0 0",
               mux_sel, ser_data, par_bit, busy);
    else passed++;
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    check_idle("post_reset");
  endtask

  task automatic test_no_parity();
    send("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    send("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0);
    send("a5_odd",  8'hA5, 1'b1, 1'b1, 1'b0);
    send("07_even", 8'h07, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_valid();
    send("ignore_valid", 8'hC3, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    P_DATA = 8'h5A; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    push_frame(8'h5A, 1'b0, 1'b0);
    @(posedge CLK); #1;
    P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    run_queue("b2b_first", 1'b0);
    check_idle("b2b_gap");
    push_frame(8'h96, 1'b1, 1'b1);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    run_queue("b2b_second", 1'b0);
    check_idle("b2b_end");
  endtask

  task automatic test_reset_mid_frame();
    @(negedge CLK);
    P_DATA = 8'hE1; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    repeat (5) begin @(posedge CLK); #1; end
    total++;
    if (mux_sel !== 2'b01 || ser_data !== 1'b0)
      $display("FAIL mid_bit4: got sel=%b ser=%b want sel=01 ser=0", mux_sel, ser_data);
    else passed++;
    RST = 1'b0;
    #1;
    total++;
    if (mux_sel !== 2'b11 || busy !== 1'b0 || ser_data !== 1'b0 || par_bit !== 1'b0)
      $display("FAIL mid_reset: got sel=%b busy=%b ser=%b par=%b want 11 0 0 0",
               mux_sel, busy, ser_data, par_bit);
    else passed++;
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_idle("after_abort");
    send("fresh_frame", 8'h3B, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_ignore_valid();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
